// File: rtl/filt_scratch_loader_pkg.sv
// Filter scratch loader shared types.
// State encoding and bank index width helper.
package filt_scratch_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BANK,
    S_CHECK,
    S_LOAD,
    S_DONE
  } state_t;

  function automatic int bank_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/filt_loader_dp.sv
// Filter loader datapath: address/word/filter counters,
// fit and limit compares, bank pointer and busy flags.
module filt_loader_dp
  import filt_scratch_loader_pkg::*;
#(
  parameter int ADDR_LEN      = 4,
  parameter int SCRATCH_DEPTH = 16,
  parameter int NUM_BANKS     = 2,
  parameter int CNT_W         = 4,
  parameter int BANK_W        = bank_w(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 latch,
  input  logic [ADDR_LEN-1:0]  filt_len,
  input  logic [CNT_W-1:0]     max_filts,
  input  logic                 clr,
  input  logic                 wr,
  input  logic                 fin,
  input  logic                 adv,
  input  logic [NUM_BANKS-1:0] bank_release,
  output logic [ADDR_LEN-1:0]  waddr,
  output logic [BANK_W-1:0]    wbank,
  output logic [CNT_W-1:0]     filt_count,
  output logic [NUM_BANKS-1:0] bank_busy,
  output logic                 cur_busy,
  output logic                 fits,
  output logic                 limit,
  output logic                 len_zero,
  output logic                 last_word
);

  localparam logic [ADDR_LEN:0] DEPTH_V =
    (ADDR_LEN+1)'(SCRATCH_DEPTH);
  localparam logic [BANK_W-1:0] LAST_BANK =
    BANK_W'(NUM_BANKS - 1);

  logic [ADDR_LEN-1:0]  len_q;
  logic [CNT_W-1:0]     max_q;
  logic [CNT_W-1:0]     cnt;
  // One extra bit so a completely full bank
  // does not wrap back to address 0.
  logic [ADDR_LEN:0]    addr;
  logic [ADDR_LEN-1:0]  word;
  logic [NUM_BANKS-1:0] set_vec;

  assign waddr     = addr[ADDR_LEN-1:0];
  assign fits      = (addr + {1'b0, len_q}) <= DEPTH_V;
  assign limit     = (max_q != '0) && (cnt == max_q);
  assign len_zero  = (len_q == '0);
  assign last_word = (word == len_q - 1'b1);
  assign cur_busy  = bank_busy[wbank];

  always_comb begin
    set_vec        = '0;
    set_vec[wbank] = fin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      max_q      <= '0;
      cnt        <= '0;
      addr       <= '0;
      word       <= '0;
      wbank      <= '0;
      filt_count <= '0;
      bank_busy  <= '0;
    end else begin
      if (latch) begin
        len_q <= filt_len;
        max_q <= max_filts;
      end
      if (clr) begin
        addr <= '0;
        word <= '0;
        cnt  <= '0;
      end else if (wr) begin
        addr <= addr + 1'b1;
        if (last_word) begin
          word <= '0;
          cnt  <= cnt + 1'b1;
        end else begin
          word <= word + 1'b1;
        end
      end
      if (fin)
        filt_count <= cnt;
      if (adv) begin
        if (wbank == LAST_BANK)
          wbank <= '0;
        else
          wbank <= wbank + 1'b1;
      end
      // Set takes priority over a same-cycle release.
      bank_busy <= (bank_busy & ~bank_release)
                 | set_vec;
    end
  end

endmodule

// File: rtl/filt_scratch_loader.sv
// Banked scratchpad filter loader: packs whole filters
// from the FIFO into one bank per start request.
module filt_scratch_loader
  import filt_scratch_loader_pkg::*;
#(
  parameter int ADDR_LEN      = 4,
  parameter int SCRATCH_DEPTH = 16,
  parameter int SCRATCH_WIDTH = 8,
  parameter int NUM_BANKS     = 2,
  parameter int CNT_W         = 4,
  parameter int BANK_W        = bank_w(NUM_BANKS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_LEN-1:0]      filt_len,
  input  logic [CNT_W-1:0]         max_filts,
  input  logic                     filt_buf_empty,
  input  logic [SCRATCH_WIDTH-1:0] filt_buf_dout,
  input  logic [NUM_BANKS-1:0]     bank_release,
  output logic                     filt_buf_read,
  output logic                     filt_scratch_wen,
  output logic [ADDR_LEN-1:0]      filt_waddr,
  output logic [SCRATCH_WIDTH-1:0] filt_wdata,
  output logic [BANK_W-1:0]        filt_wbank,
  output logic [CNT_W-1:0]         filt_count,
  output logic                     filt_ready,
  output logic                     filt_done,
  output logic [NUM_BANKS-1:0]     bank_busy
);

  state_t state_q, state_d;

  logic latch, clr, wr, fin, adv;
  logic cur_busy, fits, limit;
  logic len_zero, last_word;

  filt_loader_dp #(
    .ADDR_LEN      (ADDR_LEN),
    .SCRATCH_DEPTH (SCRATCH_DEPTH),
    .NUM_BANKS     (NUM_BANKS),
    .CNT_W         (CNT_W),
    .BANK_W        (BANK_W)
  ) u_dp (
    .clk          (clk),
    .rst          (rst),
    .latch        (latch),
    .filt_len     (filt_len),
    .max_filts    (max_filts),
    .clr          (clr),
    .wr           (wr),
    .fin          (fin),
    .adv          (adv),
    .bank_release (bank_release),
    .waddr        (filt_waddr),
    .wbank        (filt_wbank),
    .filt_count   (filt_count),
    .bank_busy    (bank_busy),
    .cur_busy     (cur_busy),
    .fits         (fits),
    .limit        (limit),
    .len_zero     (len_zero),
    .last_word    (last_word)
  );

  assign filt_wdata       = filt_buf_dout;
  assign filt_buf_read    = wr;
  assign filt_scratch_wen = wr;

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    clr     = 1'b0;
    wr      = 1'b0;
    fin     = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          latch   = 1'b1;
          state_d = S_WAIT_BANK;
        end
      end
      S_WAIT_BANK: begin
        if (!cur_busy) begin
          clr     = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (len_zero || !fits || limit) begin
          fin     = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wr = ~filt_buf_empty;
        if (wr && last_word)
          state_d = S_CHECK;
      end
      S_DONE: begin
        adv     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      filt_done  <= 1'b0;
      filt_ready <= 1'b1;
    end else begin
      state_q    <= state_d;
      filt_done  <= (state_d == S_DONE);
      filt_ready <= (state_d == S_IDLE);
    end
  end

endmodule

// File: tb/tb_filt_scratch_loader.sv
// Directed bench for filt_scratch_loader.
// FIFO model, write monitor, per-scenario tasks.
module tb_filt_scratch_loader;

  localparam int AL = 4;
  localparam int SW = 8;
  localparam int NB = 2;
  localparam int CW = 4;
  localparam int BW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AL-1:0] filt_len;
  logic [CW-1:0] max_filts;
  logic          filt_buf_empty;
  logic [SW-1:0] filt_buf_dout;
  logic [NB-1:0] bank_release;
  logic          filt_buf_read;
  logic          filt_scratch_wen;
  logic [AL-1:0] filt_waddr;
  logic [SW-1:0] filt_wdata;
  logic [BW-1:0] filt_wbank;
  logic [CW-1:0] filt_count;
  logic          filt_ready;
  logic          filt_done;
  logic [NB-1:0] bank_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;
  int wa_q[$];
  int bk_q[$];
  int wd_q[$];
  logic [7:0] head = 8'h00;
  bit pop_pend = 0;

  filt_scratch_loader dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .filt_len         (filt_len),
    .max_filts        (max_filts),
    .filt_buf_empty   (filt_buf_empty),
    .filt_buf_dout    (filt_buf_dout),
    .bank_release     (bank_release),
    .filt_buf_read    (filt_buf_read),
    .filt_scratch_wen (filt_scratch_wen),
    .filt_waddr       (filt_waddr),
    .filt_wdata       (filt_wdata),
    .filt_wbank       (filt_wbank),
    .filt_count       (filt_count),
    .filt_ready       (filt_ready),
    .filt_done        (filt_done),
    .bank_busy        (bank_busy)
  );

  always #5 clk = ~clk;

  assign filt_buf_dout = head;

  always @(negedge clk) begin
    pop_pend = 0;
    if (!rst) begin
      if (filt_buf_read) begin
        rd_cnt++;
        pop_pend = !filt_buf_empty;
      end
      if (filt_scratch_wen) begin
        wr_cnt++;
        wa_q.push_back(int'(filt_waddr));
        bk_q.push_back(int'(filt_wbank));
        wd_q.push_back(int'(filt_wdata));
      end
      if (filt_done)
        done_cnt++;
    end
  end

  always @(posedge clk)
    if (pop_pend)
      head <= head + 8'd1;

  task automatic do_reset();
    rst            = 1'b1;
    start          = 1'b0;
    filt_len       = '0;
    max_filts      = '0;
    filt_buf_empty = 1'b0;
    bank_release   = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start(input int len,
                             input int mx);
    @(posedge clk);
    #1;
    filt_len  = AL'(len);
    max_filts = CW'(mx);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output bit got,
                           output int cnt,
                           output int busy);
    got  = 0;
    cnt  = -1;
    busy = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (filt_done) begin
        got  = 1;
        cnt  = int'(filt_count);
        busy = int'(bank_busy);
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (filt_waddr !== '0)
      $display("FAIL rst_waddr: got %0d want 0",
               filt_waddr);
    else n_pass++;
    n_checks++;
    if (filt_wbank !== '0)
      $display("FAIL rst_wbank: got %0d want 0",
               filt_wbank);
    else n_pass++;
    n_checks++;
    if (filt_count !== '0)
      $display("FAIL rst_count: got %0d want 0",
               filt_count);
    else n_pass++;
    n_checks++;
    if (bank_busy !== '0)
      $display("FAIL rst_busy: got %0b want 00",
               bank_busy);
    else n_pass++;
    n_checks++;
    if (filt_done !== 1'b0 || filt_ready !== 1'b1)
      $display("FAIL rst_flags: got done=%0b rdy=%0b want 0/1",
               filt_done, filt_ready);
    else n_pass++;
    n_checks++;
    if (filt_scratch_wen !== 1'b0 ||
        filt_buf_read !== 1'b0)
      $display("FAIL rst_wen: got wen=%0b rd=%0b want 0/0",
               filt_scratch_wen, filt_buf_read);
    else n_pass++;
  endtask

  task automatic test_fill_len5();
    int base, cnt, busy, bad, dbad;
    bit got;
    do_reset();
    base = wr_cnt;
    pulse_start(5, 0);
    wait_done(got, cnt, busy);
    n_checks++;
    if (!got)
      $display("FAIL fill5_done: got timeout want pulse");
    else n_pass++;
    n_checks++;
    if (wr_cnt - base != 15)
      $display("FAIL fill5_writes: got %0d want 15",
               wr_cnt - base);
    else n_pass++;
    bad  = 0;
    dbad = 0;
    for (int i = 0; i < 15 && base + i < wa_q.size();
         i++) begin
      if (wa_q[base+i] != i || bk_q[base+i] != 0)
        bad++;
      if (i > 0 &&
          wd_q[base+i] != ((wd_q[base+i-1] + 1) & 255))
        dbad++;
    end
    n_checks++;
    if (bad != 0)
      $display("FAIL fill5_addr: got %0d bad want 0",
               bad);
    else n_pass++;
    n_checks++;
    if (dbad != 0)
      $display("FAIL fill5_data: got %0d bad want 0",
               dbad);
    else n_pass++;
    n_checks++;
    if (cnt != 3)
      $display("FAIL fill5_count: got %0d want 3", cnt);
    else n_pass++;
    n_checks++;
    if (busy != 1)
      $display("FAIL fill5_busy: got %0d want 1", busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (filt_wbank !== 1'b1 || filt_ready !== 1'b1)
      $display("FAIL fill5_next: got bank=%0d rdy=%0b want 1/1",
               filt_wbank, filt_ready);
    else n_pass++;
  endtask

  task automatic test_max2();
    int base, cnt, busy, lat, bad;
    bit got;
    do_reset();
    base = wr_cnt;
    pulse_start(4, 2);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (filt_scratch_wen) begin
        lat = k;
        break;
      end
    end
    n_checks++;
    if (lat != 3)
      $display("FAIL max2_latency: got %0d want 3", lat);
    else n_pass++;
    wait_done(got, cnt, busy);
    n_checks++;
    if (!got || cnt != 2)
      $display("FAIL max2_count: got %0d want 2", cnt);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 8 && base + i < wa_q.size(); i++)
      if (wa_q[base+i] != i) bad++;
    n_checks++;
    if (wr_cnt - base != 8 || bad != 0)
      $display("FAIL max2_writes: got %0d (bad %0d) want 8",
               wr_cnt - base, bad);
    else n_pass++;
  endtask

  task automatic test_stall();
    int base, rbase, b7, r7, cnt, busy, bad;
    bit got;
    do_reset();
    base  = wr_cnt;
    rbase = rd_cnt;
    pulse_start(5, 0);
    for (int i = 0; i < 100; i++) begin
      if (wr_cnt - base >= 7) break;
      @(posedge clk);
      #1;
    end
    filt_buf_empty = 1'b1;
    b7 = wr_cnt;
    r7 = rd_cnt;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (wr_cnt != b7 || rd_cnt != r7 || b7 - base != 7)
      $display("FAIL stall_hold: got %0d writes want 7",
               wr_cnt - base);
    else n_pass++;
    filt_buf_empty = 1'b0;
    wait_done(got, cnt, busy);
    n_checks++;
    if (!got || cnt != 3)
      $display("FAIL stall_count: got %0d want 3", cnt);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 15 && base + i < wa_q.size();
         i++)
      if (wa_q[base+i] != i) bad++;
    n_checks++;
    if (wr_cnt - base != 15 || bad != 0)
      $display("FAIL stall_writes: got %0d (bad %0d) want 15",
               wr_cnt - base, bad);
    else n_pass++;
    n_checks++;
    if (rd_cnt - rbase != 15)
      $display("FAIL stall_pops: got %0d want 15",
               rd_cnt - rbase);
    else n_pass++;
  endtask

  task automatic test_len_zero();
    int base, cnt, busy;
    bit got;
    do_reset();
    base = wr_cnt;
    pulse_start(0, 0);
    wait_done(got, cnt, busy);
    n_checks++;
    if (!got || cnt != 0)
      $display("FAIL len0_count: got %0d want 0", cnt);
    else n_pass++;
    n_checks++;
    if (busy != 1)
      $display("FAIL len0_busy: got %0d want 1", busy);
    else n_pass++;
    n_checks++;
    if (wr_cnt != base)
      $display("FAIL len0_writes: got %0d want 0",
               wr_cnt - base);
    else n_pass++;
  endtask

  task automatic test_exact_fit();
    int base, cnt, busy, bad;
    bit got;
    do_reset();
    base = wr_cnt;
    pulse_start(8, 0);
    wait_done(got, cnt, busy);
    n_checks++;
    if (!got || cnt != 2)
      $display("FAIL fit8_count: got %0d want 2", cnt);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 16 && base + i < wa_q.size();
         i++)
      if (wa_q[base+i] != i) bad++;
    n_checks++;
    if (wr_cnt - base != 16 || bad != 0)
      $display("FAIL fit8_writes: got %0d (bad %0d) want 16",
               wr_cnt - base, bad);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int base, rbase, cnt, busy, bad;
    bit got;
    do_reset();
    pulse_start(4, 1);
    wait_done(got, cnt, busy);
    pulse_start(4, 1);
    wait_done(got, cnt, busy);
    n_checks++;
    if (!got || busy != 3)
      $display("FAIL b2b_busy: got %0d want 3", busy);
    else n_pass++;
    base  = wr_cnt;
    rbase = rd_cnt;
    pulse_start(4, 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (filt_ready !== 1'b0 || filt_buf_read !== 1'b0)
        bad++;
    end
    n_checks++;
    if (bad != 0 || rd_cnt != rbase || wr_cnt != base)
      $display("FAIL b2b_wait: got %0d bad cycles want 0",
               bad);
    else n_pass++;
    n_checks++;
    if (filt_wbank !== 1'b0)
      $display("FAIL b2b_wbank: got %0d want 0",
               filt_wbank);
    else n_pass++;
    @(posedge clk);
    #1 bank_release = 2'b01;
    @(posedge clk);
    #1 bank_release = 2'b00;
    wait_done(got, cnt, busy);
    n_checks++;
    if (!got || cnt != 1 || busy != 3)
      $display("FAIL b2b_reload: got cnt=%0d busy=%0d want 1/3",
               cnt, busy);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 4 && base + i < wa_q.size(); i++)
      if (wa_q[base+i] != i || bk_q[base+i] != 0) bad++;
    n_checks++;
    if (wr_cnt - base != 4 || bad != 0)
      $display("FAIL b2b_bank0: got %0d (bad %0d) want 4",
               wr_cnt - base, bad);
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    int base, dbase, cnt, busy;
    bit got;
    do_reset();
    base  = wr_cnt;
    dbase = done_cnt;
    pulse_start(5, 0);
    for (int i = 0; i < 100; i++) begin
      if (wr_cnt - base >= 7) break;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (filt_waddr !== '0 || filt_wbank !== '0 ||
        filt_count !== '0 || bank_busy !== '0)
      $display("FAIL rstmid_regs: got a=%0d b=%0d c=%0d bb=%0b want 0",
               filt_waddr, filt_wbank, filt_count,
               bank_busy);
    else n_pass++;
    n_checks++;
    if (filt_ready !== 1'b1 || filt_done !== 1'b0 ||
        filt_scratch_wen !== 1'b0)
      $display("FAIL rstmid_flags: got rdy=%0b done=%0b wen=%0b want 1/0/0",
               filt_ready, filt_done, filt_scratch_wen);
    else n_pass++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt != dbase)
      $display("FAIL rstmid_nodone: got %0d pulses want 0",
               done_cnt - dbase);
    else n_pass++;
    base = wr_cnt;
    pulse_start(5, 0);
    wait_done(got, cnt, busy);
    n_checks++;
    if (wr_cnt - base != 15 || wa_q[base] != 0 ||
        bk_q[base] != 0)
      $display("FAIL rstmid_reload: got %0d writes want 15 from 0",
               wr_cnt - base);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill_len5();
    test_max2();
    test_stall();
    test_len_zero();
    test_exact_fit();
    test_back_to_back();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/filt_scratch_loader.md
Name: filt_scratch_loader

Overview:
Generalised successor to the single-bank filter reader. It drains filter words from the filter FIFO into a banked scratchpad and packs whole filters of run-time length back to back. Loading stops at a programmable filter count or when the next filter would not fit. NUM_BANKS banks allow double or multi-buffering: the loader fills one bank while the PE array consumes another. Each bank is held until the consumer explicitly releases it.

Parameters:
ADDR_LEN, 4, width of scratch address and filter length
SCRATCH_DEPTH, 16, words per bank (must be <= 2**ADDR_LEN)
SCRATCH_WIDTH, 8, data word width
NUM_BANKS, 2, number of scratch banks (>=1)
CNT_W, 4, width of filter-count fields
BANK_W, $clog2(NUM_BANKS) (min 1), bank index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle load request; sampled in IDLE only
filt_len  in  ADDR_LEN  words per filter; captured on accepted start
max_filts  in  CNT_W  filter limit; 0 = as many as fit; captured on accepted start
filt_buf_empty  in  1  FIFO empty (first-word-fall-through)
filt_buf_dout  in  SCRATCH_WIDTH  FIFO head word
bank_release  in  NUM_BANKS  one-hot pulse, consumer frees bank
filt_buf_read  out  1  FIFO pop
filt_scratch_wen  out  1  scratch write enable
filt_waddr  out  ADDR_LEN  scratch write address within bank
filt_wdata  out  SCRATCH_WIDTH  write data (= filt_buf_dout)
filt_wbank  out  BANK_W  target bank
filt_count  out  CNT_W  filters loaded into last completed bank
filt_ready  out  1  loader idle, start accepted
filt_done  out  1  one-cycle pulse, bank load complete
bank_busy  out  NUM_BANKS  bank holds unreleased filters

Behaviour:
- Reset: state IDLE. filt_waddr=0, filt_wbank=0, filt_count=0, bank_busy=0, filt_done=0, filt_ready=1. All outputs are registered except filt_buf_read, filt_scratch_wen and filt_wdata.
- State IDLE: filt_ready=1. On start, latch filt_len and max_filts, then go to WAIT_BANK.
- State WAIT_BANK: stay while bank_busy[filt_wbank]=1. Otherwise clear addr, filter counter and word-in-filter counter, then go to CHECK.
- State CHECK (one cycle, no writes): let fits = (addr + len <= SCRATCH_DEPTH), computed ADDR_LEN+1 bits wide, and limit = (max_filts!=0 && cnt==max_filts).
  - If len==0, or !fits, or limit: go to DONE.
  - Else go to LOAD.
- State LOAD:
  - filt_buf_read = filt_scratch_wen = ~filt_buf_empty, combinational.
  - Each write advances addr and word counter. An empty FIFO stalls with no write and no counter change.
  - On the last word of a filter (word counter == len-1 and written): cnt+1, word counter=0, go to CHECK.
- State DONE (one cycle): filt_done=1, filt_count=cnt, bank_busy[filt_wbank] set.
  - filt_wbank advances to (filt_wbank+1) mod NUM_BANKS, then go to IDLE.
  - A load that completes with cnt==0 still sets busy and advances the bank. The consumer must release it.
- bank_release[i] clears bank_busy[i] on the next edge. If release and set hit the same bank in the same cycle, set wins. Release of a non-busy bank has no effect.
- start outside IDLE is ignored. Loads are never aborted, except by rst.
- rst mid-load: immediate return to reset values. Partial bank contents are abandoned and no done pulse is produced.
- Latency: first scratch write occurs 3 cycles after accepted start (IDLE→WAIT_BANK→CHECK→LOAD), given a free bank and non-empty FIFO. Each filter boundary costs one CHECK cycle.
- Total words written = len × min(floor(SCRATCH_DEPTH/len), max_filts or ∞).

Decomposition:
- Shared package holds the state encoding (IDLE, WAIT_BANK, CHECK, LOAD, DONE) and the BANK_W derivation function.
- One natural sub-module, filt_loader_dp: address, word and filter counters, the fit/limit comparators, and the bank pointer and busy register.
- The FSM stays in the top module.

Test Plan:
- DEPTH=16, len=5, max=0, FIFO always full, 1 start → 15 writes, addr 0..14, bank 0; filt_done with filt_count=3; bank_busy=01.
- len=4, max=2 → 8 writes, addr 0..7; filt_count=2; first write exactly 3 cycles after start.
- len=5, FIFO empty for 3 cycles mid-filter-2 → no writes during stall; addresses contiguous; total 15 writes; filt_count=3.
- len=0 and len=17 (ADDR_LEN=5) → zero writes; filt_done with filt_count=0; bank busy set.
- Two back-to-back loads fill banks 0 and 1 (busy=11). Third start waits in WAIT_BANK with filt_ready=0 and no FIFO pops. bank_release=01 → load proceeds into bank 0.
- rst asserted after 7 writes of len=5 → next cycle all outputs at reset values, no filt_done; a subsequent start reloads from addr 0, bank 0.
